// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
// Contents: FSM state enum, response error-code enum, funct3 width codes,
// and small decode helpers (legality, alignment, byte enables, store lanes).
package rv32i_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2,
        RESP       = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } lsu_err_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have signed widths; the unsigned codes are load-only.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = a[0];
            F3_W:        mis = (a != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << a;
            F3_H, F3_HU: be = 4'b0011 << a;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicating the low byte/half fills every lane, so the enabled lane
    // always carries the data regardless of the address offset.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rv32i_lsu_load_align.sv
// Load data alignment: selects the addressed byte/half lane of the raw
// memory word and sign- or zero-extends it according to funct3.
// Ports: funct3_i (width code), addr_lo_i (byte offset), rdata_i (raw word),
//        data_o (extended result). Purely combinational.
module rv32i_lsu_load_align
    import rv32i_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;

    // Bring the addressed lane down to bit 0; word loads have offset 0.
    assign shifted_s = rdata_i >> {addr_lo_i, 3'b000};

    // Extend the selected lane to 32 bits
    always_comb begin
        data_o = 32'd0;
        case (funct3_i)
            F3_B:    data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    data_o = shifted_s;
            F3_BU:   data_o = {24'd0, shifted_s[7:0]};
            F3_HU:   data_o = {16'd0, shifted_s[15:0]};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: accepts one operation at a time from the pipeline,
// issues a single-cycle memory request, waits for the matching completion
// and returns an extended/error-tagged response.
// Ports: clk_i, rst_ni (synchronous, active-low); op_* (operation handshake);
//        mem_* (request outputs, rvalid/rdata/wack completions);
//        rsp_* (response handshake, data, error flag and code).
// Optional feature: define RV32I_LSU_TIMEOUT_EN to abort a wait after
// TIMEOUT_CYCLES cycles with error code 10; otherwise waits are unbounded.
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic        op_we_i,
    input  logic [2:0]  op_funct3_i,
    input  logic [31:0] op_addr_i,
    input  logic [31:0] op_wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_wack_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  rsp_err_code_o
);

    if ((TIMEOUT_CYCLES < 32'd2) || (TIMEOUT_CYCLES > 32'd255)) begin : g_bad_timeout
        $error("rv32i_lsu: TIMEOUT_CYCLES must be within 2..255");
    end

    lsu_state_e  state_r, state_s;
    logic        op_ready_r, op_ready_s;
    logic        mem_req_r, mem_req_s;
    logic        mem_we_r, mem_we_s;
    logic [3:0]  mem_be_r, mem_be_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [31:0] rsp_rdata_r, rsp_rdata_s;
    logic        rsp_err_r, rsp_err_s;
    lsu_err_e    rsp_err_code_r, rsp_err_code_s;
    logic [2:0]  op_funct3_r, op_funct3_s;
    logic [1:0]  op_addr_lo_r, op_addr_lo_s;
    logic [31:0] load_data_s;
    logic        timeout_s;

    rv32i_lsu_load_align u_load_align (
        .funct3_i  (op_funct3_r),
        .addr_lo_i (op_addr_lo_r),
        .rdata_i   (mem_rdata_i),
        .data_o    (load_data_s)
    );

`ifdef RV32I_LSU_TIMEOUT_EN
    logic [7:0] tmo_cnt_r;

    // Count cycles spent waiting for a completion; cleared in any other state
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_cnt_r <= 8'd0;
        end else if ((state_r == LOAD_WAIT) || (state_r == STORE_WAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= 8'd0;
        end
    end

    // Counter is 0 in the first wait cycle, so TIMEOUT_CYCLES-1 marks the last one.
    assign timeout_s = (tmo_cnt_r == 8'(TIMEOUT_CYCLES - 32'd1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_s        = state_r;
        mem_req_s      = 1'b0;
        mem_we_s       = mem_we_r;
        mem_be_s       = mem_be_r;
        mem_addr_s     = mem_addr_r;
        mem_wdata_s    = mem_wdata_r;
        rsp_valid_s    = rsp_valid_r;
        rsp_rdata_s    = rsp_rdata_r;
        rsp_err_s      = rsp_err_r;
        rsp_err_code_s = rsp_err_code_r;
        op_funct3_s    = op_funct3_r;
        op_addr_lo_s   = op_addr_lo_r;
        case (state_r)
            IDLE: begin
                if (op_valid_i) begin
                    op_funct3_s  = op_funct3_i;
                    op_addr_lo_s = op_addr_i[1:0];
                    if (!f3_legal(op_we_i, op_funct3_i)) begin
                        state_s        = RESP;
                        rsp_valid_s    = 1'b1;
                        rsp_rdata_s    = 32'd0;
                        rsp_err_s      = 1'b1;
                        rsp_err_code_s = ERR_ILLEGAL;
                    end else if (f3_misaligned(op_funct3_i, op_addr_i[1:0])) begin
                        state_s        = RESP;
                        rsp_valid_s    = 1'b1;
                        rsp_rdata_s    = 32'd0;
                        rsp_err_s      = 1'b1;
                        rsp_err_code_s = ERR_MISALIGN;
                    end else begin
                        state_s     = op_we_i ? STORE_WAIT : LOAD_WAIT;
                        mem_req_s   = 1'b1;
                        mem_we_s    = op_we_i;
                        mem_be_s    = byte_enable(op_funct3_i, op_addr_i[1:0]);
                        mem_addr_s  = {op_addr_i[31:2], 2'b00};
                        mem_wdata_s = store_lanes(op_funct3_i, op_wdata_i);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_WAIT: begin
                // A real completion wins over a timeout in the same cycle.
                if (mem_rvalid_i) begin
                    state_s        = RESP;
                    rsp_valid_s    = 1'b1;
                    rsp_rdata_s    = load_data_s;
                    rsp_err_s      = 1'b0;
                    rsp_err_code_s = ERR_NONE;
                end else if (timeout_s) begin
                    state_s        = RESP;
                    rsp_valid_s    = 1'b1;
                    rsp_rdata_s    = 32'd0;
                    rsp_err_s      = 1'b1;
                    rsp_err_code_s = ERR_TIMEOUT;
                end else begin
                    state_s = LOAD_WAIT;
                end
            end
            STORE_WAIT: begin
                if (mem_wack_i) begin
                    state_s        = RESP;
                    rsp_valid_s    = 1'b1;
                    rsp_rdata_s    = 32'd0;
                    rsp_err_s      = 1'b0;
                    rsp_err_code_s = ERR_NONE;
                end else if (timeout_s) begin
                    state_s        = RESP;
                    rsp_valid_s    = 1'b1;
                    rsp_rdata_s    = 32'd0;
                    rsp_err_s      = 1'b1;
                    rsp_err_code_s = ERR_TIMEOUT;
                end else begin
                    state_s = STORE_WAIT;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_s     = IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s     = IDLE;
                rsp_valid_s = 1'b0;
            end
        endcase
        op_ready_s = (state_s == IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r        <= IDLE;
            op_ready_r     <= 1'b1;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_be_r       <= 4'd0;
            mem_addr_r     <= 32'd0;
            mem_wdata_r    <= 32'd0;
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= 32'd0;
            rsp_err_r      <= 1'b0;
            rsp_err_code_r <= ERR_NONE;
            op_funct3_r    <= 3'd0;
            op_addr_lo_r   <= 2'd0;
        end else begin
            state_r        <= state_s;
            op_ready_r     <= op_ready_s;
            mem_req_r      <= mem_req_s;
            mem_we_r       <= mem_we_s;
            mem_be_r       <= mem_be_s;
            mem_addr_r     <= mem_addr_s;
            mem_wdata_r    <= mem_wdata_s;
            rsp_valid_r    <= rsp_valid_s;
            rsp_rdata_r    <= rsp_rdata_s;
            rsp_err_r      <= rsp_err_s;
            rsp_err_code_r <= rsp_err_code_s;
            op_funct3_r    <= op_funct3_s;
            op_addr_lo_r   <= op_addr_lo_s;
        end
    end

    assign op_ready_o     = op_ready_r;
    assign mem_req_o      = mem_req_r;
    assign mem_we_o       = mem_we_r;
    assign mem_be_o       = mem_be_r;
    assign mem_addr_o     = mem_addr_r;
    assign mem_wdata_o    = mem_wdata_r;
    assign rsp_valid_o    = rsp_valid_r;
    assign rsp_rdata_o    = rsp_rdata_r;
    assign rsp_err_o      = rsp_err_r;
    assign rsp_err_code_o = rsp_err_code_r;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard testbench for rv32i_lsu: stimulus pushes expected memory
// requests and responses into queues; a negedge monitor pops and compares
// whenever the DUT presents mem_req_o or completes a response handshake.
module tb_rv32i_lsu;

`ifdef RV32I_LSU_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 32;
`endif

    localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        op_valid_i = 1'b0;
    logic        op_ready_o;
    logic        op_we_i = 1'b0;
    logic [2:0]  op_funct3_i = 3'd0;
    logic [31:0] op_addr_i = 32'd0;
    logic [31:0] op_wdata_i = 32'd0;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        mem_wack_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [1:0]  rsp_err_code_o;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  code;
        logic        chk_rdata;
    } rsp_exp_t;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];
    int checks = 0;
    int errors = 0;

    rv32i_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_we_i(op_we_i),
        .op_funct3_i(op_funct3_i), .op_addr_i(op_addr_i), .op_wdata_i(op_wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_wack_i(mem_wack_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_err_code_o(rsp_err_code_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Monitor: compare every request pulse and every response handshake
    always @(negedge clk_i) begin : monitor
        mem_exp_t me;
        rsp_exp_t re;
        logic [31:0] m;
        if (rst_ni) begin
            if (mem_req_o) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'(mem_req_o), 32'd0);
                end else begin
                    me = mem_q.pop_front();
                    m = me.we ? lane_mask(me.be) : 32'd0;
                    chk("mem_we", 32'(mem_we_o), 32'(me.we));
                    chk("mem_be", 32'(mem_be_o), 32'(me.be));
                    chk("mem_addr", mem_addr_o, me.addr);
                    chk("mem_wdata", mem_wdata_o & m, me.wdata & m);
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_err_code", 32'(rsp_err_code_o), 32'(re.code));
                    chk("rsp_err", 32'(rsp_err_o), 32'(re.code != 2'b00));
                    if (re.chk_rdata) chk("rsp_rdata", rsp_rdata_o, re.rdata);
                end
            end
        end
    end

    task automatic exp_mem(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wd);
        mem_exp_t e;
        e.we = we; e.be = be; e.addr = addr; e.wdata = wd;
        mem_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic [31:0] rdata, input logic [1:0] code, input logic cr);
        rsp_exp_t e;
        e.rdata = rdata; e.code = code; e.chk_rdata = cr;
        rsp_q.push_back(e);
    endtask

    // Called and returns at posedge+1; the op is accepted at the edge inside.
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int n = 0;
        while (!op_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("op_ready_before_issue", 32'(op_ready_o), 32'd1);
        op_valid_i = 1'b1; op_we_i = we; op_funct3_i = f3; op_addr_i = addr; op_wdata_i = wd;
        @(posedge clk_i); #1;
        op_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rsp_q.size() != 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("rsp_drained", 32'(rsp_q.size()), 32'd0);
        rsp_q.delete();
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] raw,
                        input logic [3:0] be, input logic [31:0] exp_data);
        exp_mem(1'b0, be, {addr[31:2], 2'b00}, 32'd0);
        exp_rsp(exp_data, 2'b00, 1'b1);
        do_op(1'b0, f3, addr, 32'd0);
        mem_rvalid_i = 1'b1; mem_rdata_i = raw;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        drain();
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] lanes);
        exp_mem(1'b1, be, {addr[31:2], 2'b00}, lanes);
        exp_rsp(32'd0, 2'b00, 1'b1);
        do_op(1'b1, f3, addr, wd);
        mem_wack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_wack_i = 1'b0;
        drain();
    endtask

    task automatic bad_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [1:0] code);
        exp_rsp(32'd0, code, 1'b0);
        do_op(we, f3, addr, 32'h5A5A_5A5A);
        @(negedge clk_i);
        chk("err_rsp_valid_t1", 32'(rsp_valid_o), 32'd1);
        chk("err_no_mem_req", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;
        drain();
    endtask

    initial begin
        // Reset values, sampled while reset is held
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_op_ready", 32'(op_ready_o), 32'd1);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_be", 32'(mem_be_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_code", 32'(rsp_err_code_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Stray completions in IDLE are ignored
        mem_rvalid_i = 1'b1; mem_wack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0; mem_wack_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            chk("idle_stray_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        @(posedge clk_i); #1;

        // Stores
        store(FB, 32'h0000_0103, 32'h0000_00AB, 4'b1000, 32'hAB00_0000);
        store(FH, 32'h0000_0012, 32'h1234_BEEF, 4'b1100, 32'hBEEF_0000);
        store(FW, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        store(FB, 32'h0000_0041, 32'h0000_0077, 4'b0010, 32'h0000_7700);

        // Loads
        load(FH,  32'h0000_0202, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
        load(FHU, 32'h0000_0202, 32'h8001_1234, 4'b1100, 32'h0000_8001);
        load(FB,  32'h0000_0301, 32'h0000_8000, 4'b0010, 32'hFFFF_FF80);
        load(FBU, 32'h0000_0303, 32'h7F00_0000, 4'b1000, 32'h0000_007F);
        load(FW,  32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        load(FH,  32'h0000_0200, 32'h8001_7FFE, 4'b0011, 32'h0000_7FFE);

        // Misaligned and illegal
        bad_op(1'b0, FW, 32'h0000_0006, 2'b01);
        bad_op(1'b0, FH, 32'h0000_0105, 2'b01);
        bad_op(1'b1, FW, 32'h0000_0002, 2'b01);
        bad_op(1'b0, 3'b011, 32'h0000_0000, 2'b11);
        bad_op(1'b1, FBU, 32'h0000_0000, 2'b11);

        // Mismatched completions: wack in LOAD_WAIT, rvalid in STORE_WAIT
        exp_mem(1'b0, 4'b0001, 32'h0000_0000, 32'd0);
        exp_rsp(32'h0000_0042, 2'b00, 1'b1);
        do_op(1'b0, FB, 32'h0000_0000, 32'd0);
        mem_wack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_wack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0042;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        drain();
        exp_mem(1'b1, 4'b1111, 32'h0000_0030, 32'h1122_3344);
        exp_rsp(32'd0, 2'b00, 1'b1);
        do_op(1'b1, FW, 32'h0000_0030, 32'h1122_3344);
        mem_rvalid_i = 1'b1;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0; mem_wack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_wack_i = 1'b0;
        drain();

        // Response back-pressure: outputs hold for 5 cycles
        rsp_ready_i = 1'b0;
        exp_mem(1'b0, 4'b1111, 32'h0000_0010, 32'd0);
        exp_rsp(32'h1357_9BDF, 2'b00, 1'b1);
        do_op(1'b0, FW, 32'h0000_0010, 32'd0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("stall_rsp_rdata", rsp_rdata_o, 32'h1357_9BDF);
            chk("stall_rsp_code", 32'(rsp_err_code_o), 32'd0);
            chk("stall_op_ready", 32'(op_ready_o), 32'd0);
        end
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        drain();

`ifdef RV32I_LSU_TIMEOUT_EN
        // Timeout after 4 wait cycles; late rvalid ignored
        rsp_ready_i = 1'b0;
        exp_mem(1'b0, 4'b1111, 32'h0000_0500, 32'd0);
        exp_rsp(32'd0, 2'b10, 1'b1);
        do_op(1'b0, FW, 32'h0000_0500, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i);
            chk("tmo_waiting", 32'(rsp_valid_o), 32'd0);
        end
        @(negedge clk_i);
        chk("tmo_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("tmo_rsp_code", 32'(rsp_err_code_o), 32'd2);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        rsp_ready_i = 1'b1;
        drain();
        repeat (3) begin
            @(negedge clk_i);
            chk("tmo_late_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        @(posedge clk_i); #1;
`endif

        // Reset while in LOAD_WAIT abandons the access
        exp_mem(1'b0, 4'b1111, 32'h0000_0600, 32'd0);
        do_op(1'b0, FW, 32'h0000_0600, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        chk("midrst_op_ready", 32'(op_ready_o), 32'd1);
        chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
        chk("midrst_mem_addr", mem_addr_o, 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk("late_rvalid_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        @(posedge clk_i); #1;

        chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
